// File: rtl/lsu_ecc_scrub.sv
// Queues corrected DCCM words on single-bit ECC errors and writes them back with
// (39,32) SECDED check bits over a req/gnt port; req appears one cycle after the push.
module lsu_ecc_scrub #(
  parameter int DCCM_BITS = 16,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dec_tlu_core_ecc_disable,
  input  logic                 single_ecc_error_lo_dc3,
  input  logic                 single_ecc_error_hi_dc3,
  input  logic [DCCM_BITS-1:0] lsu_addr_dc3,
  input  logic [DCCM_BITS-1:0] end_addr_dc3,
  input  logic [31:0]          sec_data_lo_dc3,
  input  logic [31:0]          sec_data_hi_dc3,
  output logic                 dccm_wr_req,
  input  logic                 dccm_wr_gnt,
  output logic [DCCM_BITS-1:0] dccm_wr_addr,
  output logic [38:0]          dccm_wr_data,
  output logic                 scrub_busy,
  output logic                 scrub_overflow
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [DCCM_BITS-1:0] WORD_MASK = ~DCCM_BITS'(3);

  typedef enum logic {IDLE, REQ} state_e;

  // Hamming check bits are the XOR of the codeword positions of all set data bits;
  // data occupies positions 3..38 skipping powers of two, bit 6 is overall parity.
  function automatic logic [6:0] ecc_encode(input logic [31:0] din);
    logic [6:0] ecc;
    int         di;
    ecc = '0;
    di  = 0;
    for (int p = 3; p < 39; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (din[di[4:0]]) ecc[5:0] = ecc[5:0] ^ p[5:0];
        di++;
      end
    end
    ecc[6] = ^{din, ecc[5:0]};
    return ecc;
  endfunction

  state_e                 state_q, state_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, hi_slot;
  logic [CW-1:0]          count_q, count_d, free;
  logic [DCCM_BITS-1:0]   addr_mem_q [DEPTH];
  logic [DCCM_BITS-1:0]   addr_mem_d [DEPTH];
  logic [38:0]            data_mem_q [DEPTH];
  logic [38:0]            data_mem_d [DEPTH];
  logic                   wr_req_q, wr_req_d, busy_q, busy_d, ovf_q, ovf_d;
  logic [DCCM_BITS-1:0]   wr_addr_q, wr_addr_d;
  logic [38:0]            wr_data_q, wr_data_d;
  logic                   pop, lo_push, hi_push, acc_lo, acc_hi;

  always_comb begin
    pop        = (state_q == REQ) && dccm_wr_gnt;
    lo_push    = single_ecc_error_lo_dc3 && !dec_tlu_core_ecc_disable;
    hi_push    = single_ecc_error_hi_dc3 && !dec_tlu_core_ecc_disable;
    free       = CW'(DEPTH) - count_q + CW'(pop);
    // lo claims the first free slot, so hi is the one dropped when only one is left
    acc_lo     = lo_push && (free != '0);
    acc_hi     = hi_push && (free > CW'(acc_lo));
    hi_slot    = wr_ptr_q + PW'(acc_lo);
    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;
    if (acc_lo) begin
      addr_mem_d[wr_ptr_q] = lsu_addr_dc3 & WORD_MASK;
      data_mem_d[wr_ptr_q] = {ecc_encode(sec_data_lo_dc3), sec_data_lo_dc3};
    end
    if (acc_hi) begin
      addr_mem_d[hi_slot] = end_addr_dc3 & WORD_MASK;
      data_mem_d[hi_slot] = {ecc_encode(sec_data_hi_dc3), sec_data_hi_dc3};
    end
    wr_ptr_d  = hi_slot + PW'(acc_hi);
    rd_ptr_d  = rd_ptr_q + PW'(pop);
    count_d   = count_q + CW'(acc_lo) + CW'(acc_hi) - CW'(pop);
    state_d   = (count_d != '0) ? REQ : IDLE;
    // outputs are registered from the next-state head so a fresh push is visible next cycle
    wr_req_d  = (state_d == REQ);
    wr_addr_d = wr_req_d ? addr_mem_d[rd_ptr_d] : '0;
    wr_data_d = wr_req_d ? data_mem_d[rd_ptr_d] : '0;
    busy_d    = (count_d != '0);
    ovf_d     = (lo_push && !acc_lo) || (hi_push && !acc_hi);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      wr_req_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      addr_mem_q <= addr_mem_d;
      data_mem_q <= data_mem_d;
      wr_req_q   <= wr_req_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
    end
  end

  assign dccm_wr_req    = wr_req_q;
  assign dccm_wr_addr   = wr_addr_q;
  assign dccm_wr_data   = wr_data_q;
  assign scrub_busy     = busy_q;
  assign scrub_overflow = ovf_q;

endmodule

// File: tb/tb_lsu_ecc_scrub.sv
// Scoreboard bench for lsu_ecc_scrub: expected writes are queued at push time and
// compared when the DUT transfers; ECC checked against an independent SECDED model.
module tb_lsu_ecc_scrub;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        dis, err_lo, err_hi, gnt;
  logic [15:0] lsu_addr, end_addr;
  logic [31:0] dat_lo, dat_hi;
  logic        dccm_wr_req, scrub_busy, scrub_overflow;
  logic [15:0] dccm_wr_addr;
  logic [38:0] dccm_wr_data;

  int          checks = 0;
  int          fails  = 0;
  logic [54:0] exp_q[$];
  logic        exp_drop;

  always #5 clk = ~clk;

  lsu_ecc_scrub #(.DCCM_BITS(16), .DEPTH(DEPTH)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .dec_tlu_core_ecc_disable(dis),
    .single_ecc_error_lo_dc3 (err_lo),
    .single_ecc_error_hi_dc3 (err_hi),
    .lsu_addr_dc3            (lsu_addr),
    .end_addr_dc3            (end_addr),
    .sec_data_lo_dc3         (dat_lo),
    .sec_data_hi_dc3         (dat_hi),
    .dccm_wr_req             (dccm_wr_req),
    .dccm_wr_gnt             (gnt),
    .dccm_wr_addr            (dccm_wr_addr),
    .dccm_wr_data            (dccm_wr_data),
    .scrub_busy              (scrub_busy),
    .scrub_overflow          (scrub_overflow)
  );

  // Classic Hamming: parity bit k covers every codeword position with bit k set.
  function automatic logic [6:0] gold_ecc(input logic [31:0] d);
    logic [38:0] cw;
    logic [6:0]  e;
    int          di;
    cw = '0; e = '0; di = 0;
    for (int p = 1; p <= 38; p++)
      if ((p & (p - 1)) != 0) begin cw[p[5:0]] = d[di[4:0]]; di++; end
    for (int k = 0; k < 6; k++)
      for (int p = 1; p <= 38; p++)
        if (((p >> k) & 1) == 1) e[k[2:0]] = e[k[2:0]] ^ cw[p[5:0]];
    e[6] = (^d) ^ (^e[5:0]);
    return e;
  endfunction

  function automatic logic [31:0] gold_dec(input logic [38:0] w);
    logic [38:0] cw;
    logic [31:0] d;
    logic [5:0]  s;
    int          di;
    cw = '0; d = '0; s = '0; di = 0;
    for (int k = 0; k < 6; k++) cw[6'(1 << k)] = w[6'(32 + k)];
    for (int p = 1; p <= 38; p++)
      if ((p & (p - 1)) != 0) begin cw[p[5:0]] = w[di[5:0]]; di++; end
    for (int p = 1; p <= 38; p++)
      if (cw[p[5:0]]) s = s ^ p[5:0];
    if ((^w) && s != 0 && s <= 38) cw[s] = ~cw[s];
    di = 0;
    for (int p = 1; p <= 38; p++)
      if ((p & (p - 1)) != 0) begin d[di[4:0]] = cw[p[5:0]]; di++; end
    return d;
  endfunction

  // Present one cycle of inputs, update the model, then step to 1 time unit past the edge.
  task automatic drive(input logic lo, input logic hi, input logic [15:0] la, input logic [15:0] ea,
                       input logic [31:0] dl, input logic [31:0] dh, input logic g, input logic d_s);
    int free;
    bit pop, ok_lo, ok_hi;
    err_lo = lo; err_hi = hi; lsu_addr = la; end_addr = ea;
    dat_lo = dl; dat_hi = dh; gnt = g; dis = d_s;
    exp_drop = 1'b0;
    if (rst) begin
      exp_q.delete();
    end else begin
      pop   = g && (exp_q.size() != 0);
      free  = DEPTH - exp_q.size() + int'(pop);
      ok_lo = lo && !d_s && (free >= 1);
      ok_hi = hi && !d_s && (free >= (ok_lo ? 2 : 1));
      if (ok_lo) exp_q.push_back({la & 16'hfffc, gold_ecc(dl), dl});
      if (ok_hi) exp_q.push_back({ea & 16'hfffc, gold_ecc(dh), dh});
      exp_drop = (lo && !d_s && !ok_lo) || (hi && !d_s && !ok_hi);
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && dccm_wr_req === 1'b1 && gnt === 1'b1) begin
      logic [54:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", dccm_wr_addr, dccm_wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({dccm_wr_addr, dccm_wr_data} !== e) begin
          fails++;
          $display("FAIL write_entry: got %h_%h expected %h_%h", dccm_wr_addr, dccm_wr_data, e[54:39], e[38:0]);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 1, 16'h0010, 16'h0014, 32'hdead, 32'hbeef, 0, 0);
    drive(1, 0, 16'h0020, 16'h0000, 32'h1234, 32'h0, 0, 0);
    checks++; if (dccm_wr_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %0b expected 0", dccm_wr_req); end
    checks++; if (dccm_wr_addr !== 16'h0) begin fails++; $display("FAIL reset_addr: got %h expected 0", dccm_wr_addr); end
    checks++; if (dccm_wr_data !== 39'h0) begin fails++; $display("FAIL reset_data: got %h expected 0", dccm_wr_data); end
    checks++; if (scrub_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b expected 0", scrub_busy); end
    checks++; if (scrub_overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %0b expected 0", scrub_overflow); end
    rst = 1'b0;
    drive(0, 0, 16'h0, 16'h0, 32'h0, 32'h0, 1, 0);
    checks++; if (dccm_wr_req !== 1'b0) begin fails++; $display("FAIL reset_push_ignored: got req %0b expected 0", dccm_wr_req); end
  endtask

  task automatic test_single();
    drive(1, 0, 16'h0106, 16'h0000, 32'h0, 32'h0, 1, 0);
    checks++; if (dccm_wr_req !== 1'b1) begin fails++; $display("FAIL single_req: got %0b expected 1", dccm_wr_req); end
    checks++; if (dccm_wr_addr !== 16'h0104) begin fails++; $display("FAIL single_addr: got %h expected 0104", dccm_wr_addr); end
    checks++; if (dccm_wr_data !== 39'h0) begin fails++; $display("FAIL single_data: got %h expected 0", dccm_wr_data); end
    checks++; if (scrub_busy !== 1'b1) begin fails++; $display("FAIL single_busy: got %0b expected 1", scrub_busy); end
    drive(0, 0, 16'h0, 16'h0, 32'h0, 32'h0, 1, 0);
    checks++; if (dccm_wr_req !== 1'b0) begin fails++; $display("FAIL single_req_drop: got %0b expected 0", dccm_wr_req); end
    checks++; if (scrub_busy !== 1'b0) begin fails++; $display("FAIL single_idle_busy: got %0b expected 0", scrub_busy); end
    checks++; if (dccm_wr_addr !== 16'h0) begin fails++; $display("FAIL single_idle_addr: got %h expected 0", dccm_wr_addr); end
  endtask

  task automatic test_dual();
    drive(1, 1, 16'h0006, 16'h0009, 32'hcafe_0001, 32'hcafe_0002, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (dccm_wr_req !== 1'b1 || dccm_wr_addr !== 16'h0004) begin
        fails++; $display("FAIL dual_hold: got req %0b addr %h expected 1 0004", dccm_wr_req, dccm_wr_addr); end
      drive(0, 0, 16'h0, 16'h0, 32'h0, 32'h0, (i == 2), 0);
    end
    checks++; if (dccm_wr_req !== 1'b1 || dccm_wr_addr !== 16'h0008) begin
      fails++; $display("FAIL dual_second: got req %0b addr %h expected 1 0008", dccm_wr_req, dccm_wr_addr); end
    drive(0, 0, 16'h0, 16'h0, 32'h0, 32'h0, 1, 0);
    checks++; if (dccm_wr_req !== 1'b0) begin fails++; $display("FAIL dual_done: got %0b expected 0", dccm_wr_req); end
  endtask

  task automatic test_ecc();
    logic [38:0] w;
    drive(1, 0, 16'h0200, 16'h0, 32'h1, 32'h0, 0, 0);
    w = dccm_wr_data;
    checks++; if (w !== {7'h43, 32'h1}) begin fails++; $display("FAIL ecc_one: got %h expected %h", w, {7'h43, 32'h1}); end
    checks++; if (w[38:32] !== gold_ecc(32'h1)) begin fails++; $display("FAIL ecc_gold: got %h expected %h", w[38:32], gold_ecc(32'h1)); end
    for (int i = 0; i < 39; i++) begin
      logic [38:0] flip;
      flip = w ^ (39'h1 << i);
      checks++; if (gold_dec(flip) !== 32'h1) begin
        fails++; $display("FAIL ecc_correct_bit%0d: got %h expected 00000001", i, gold_dec(flip)); end
    end
    drive(0, 0, 16'h0, 16'h0, 32'h0, 32'h0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      drive(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), $urandom, $urandom, 1, 0);
      checks++; if (scrub_overflow !== exp_drop) begin
        fails++; $display("FAIL ecc_rand_ovf: got %0b expected %0b", scrub_overflow, exp_drop); end
    end
    for (int i = 0; i < 5; i++) drive(0, 0, 16'h0, 16'h0, 32'h0, 32'h0, 1, 0);
    checks++; if (exp_q.size() != 0 || dccm_wr_req !== 1'b0) begin
      fails++; $display("FAIL ecc_drain: got %0d pending req %0b expected 0 0", exp_q.size(), dccm_wr_req); end
  endtask

  task automatic test_overflow();
    drive(1, 1, 16'h0100, 16'h0104, 32'h11, 32'h22, 0, 0);
    drive(1, 1, 16'h0108, 16'h010c, 32'h33, 32'h44, 0, 0);
    checks++; if (scrub_busy !== 1'b1 || scrub_overflow !== 1'b0) begin
      fails++; $display("FAIL ovf_fill: got busy %0b ovf %0b expected 1 0", scrub_busy, scrub_overflow); end
    drive(1, 1, 16'h0110, 16'h0114, 32'h55, 32'h66, 0, 0);
    checks++; if (scrub_overflow !== 1'b1) begin fails++; $display("FAIL ovf_full_dual: got %0b expected 1", scrub_overflow); end
    drive(0, 0, 16'h0, 16'h0, 32'h0, 32'h0, 0, 0);
    checks++; if (scrub_overflow !== 1'b0) begin fails++; $display("FAIL ovf_pulse_width: got %0b expected 0", scrub_overflow); end
    drive(1, 1, 16'h0118, 16'h011c, 32'h77, 32'h88, 1, 0);
    checks++; if (scrub_overflow !== 1'b1) begin fails++; $display("FAIL ovf_hi_drop: got %0b expected 1", scrub_overflow); end
    checks++; if (dccm_wr_addr !== 16'h0104) begin fails++; $display("FAIL ovf_head_adv: got %h expected 0104", dccm_wr_addr); end
    for (int i = 0; i < 4; i++) drive(0, 0, 16'h0, 16'h0, 32'h0, 32'h0, 1, 0);
    checks++; if (exp_q.size() != 0 || dccm_wr_req !== 1'b0) begin
      fails++; $display("FAIL ovf_drain: got %0d pending req %0b expected 0 0", exp_q.size(), dccm_wr_req); end
  endtask

  task automatic test_disable();
    drive(1, 1, 16'h0300, 16'h0304, 32'haa, 32'hbb, 1, 1);
    checks++; if (dccm_wr_req !== 1'b0 || scrub_overflow !== 1'b0) begin
      fails++; $display("FAIL dis_no_push: got req %0b ovf %0b expected 0 0", dccm_wr_req, scrub_overflow); end
    drive(1, 1, 16'h0310, 16'h0314, 32'hcc, 32'hdd, 0, 0);
    drive(0, 0, 16'h0, 16'h0, 32'h0, 32'h0, 0, 1);
    checks++; if (dccm_wr_req !== 1'b1) begin fails++; $display("FAIL dis_keep_req: got %0b expected 1", dccm_wr_req); end
    drive(1, 0, 16'h0320, 16'h0, 32'hee, 32'h0, 1, 1);
    drive(0, 0, 16'h0, 16'h0, 32'h0, 32'h0, 1, 1);
    checks++; if (exp_q.size() != 0 || dccm_wr_req !== 1'b0) begin
      fails++; $display("FAIL dis_drain: got %0d pending req %0b expected 0 0", exp_q.size(), dccm_wr_req); end
  endtask

  task automatic test_reset_in_req();
    drive(1, 0, 16'h0400, 16'h0, 32'h5a5a, 32'h0, 0, 0);
    checks++; if (dccm_wr_req !== 1'b1) begin fails++; $display("FAIL rstreq_setup: got %0b expected 1", dccm_wr_req); end
    rst = 1'b1;
    drive(0, 0, 16'h0, 16'h0, 32'h0, 32'h0, 1, 0);
    rst = 1'b0;
    checks++; if (dccm_wr_req !== 1'b0 || scrub_busy !== 1'b0) begin
      fails++; $display("FAIL rstreq_clear: got req %0b busy %0b expected 0 0", dccm_wr_req, scrub_busy); end
    drive(0, 0, 16'h0, 16'h0, 32'h0, 32'h0, 1, 0);
    drive(0, 0, 16'h0, 16'h0, 32'h0, 32'h0, 1, 0);
    checks++; if (dccm_wr_req !== 1'b0) begin fails++; $display("FAIL rstreq_stay_idle: got %0b expected 0", dccm_wr_req); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++)
      drive(1, 1, 16'(16'h0500 + 16'(8 * i)), 16'(16'h0504 + 16'(8 * i)), $urandom, $urandom, 1, 0);
    checks++; if (exp_q.size() != 4) begin fails++; $display("FAIL b2b_model_fill: got %0d expected 4", exp_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (dccm_wr_req !== 1'b1) begin fails++; $display("FAIL b2b_req%0d: got %0b expected 1", i, dccm_wr_req); end
      drive(0, 0, 16'h0, 16'h0, 32'h0, 32'h0, 1, 0);
    end
    checks++; if (exp_q.size() != 0 || dccm_wr_req !== 1'b0) begin
      fails++; $display("FAIL b2b_drain: got %0d pending req %0b expected 0 0", exp_q.size(), dccm_wr_req); end
  endtask

  initial begin
    rst = 1'b1; dis = 1'b0; err_lo = 1'b0; err_hi = 1'b0; gnt = 1'b0;
    lsu_addr = '0; end_addr = '0; dat_lo = '0; dat_hi = '0; exp_drop = 1'b0;
    test_reset();
    test_single();
    test_dual();
    test_ecc();
    test_overflow();
    test_disable();
    test_reset_in_req();
    test_back_to_back();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/lsu_ecc_scrub.md
LSU_ECC_SCRUB -- requirements
Module: lsu_ecc_scrub

Interface
REQ-001 Parameter DCCM_BITS, default 16, SHALL set the DCCM byte-address width.
REQ-002 Parameter DEPTH, default 4, SHALL set the scrub queue depth; legal values are powers of two, 2 or greater.
REQ-003 Port clk, input, 1: the single clock; the block SHALL use no other clock.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port dec_tlu_core_ecc_disable, input, 1: when 1, the block SHALL NOT accept new scrub entries.
REQ-006 Port single_ecc_error_lo_dc3, input, 1: correctable error on the lo bank.
REQ-007 Port single_ecc_error_hi_dc3, input, 1: correctable error on the hi bank.
REQ-008 Port lsu_addr_dc3, input, DCCM_BITS: access start address.
REQ-009 Port end_addr_dc3, input, DCCM_BITS: access end address.
REQ-010 Port sec_data_lo_dc3, input, 32: corrected lo-bank word.
REQ-011 Port sec_data_hi_dc3, input, 32: corrected hi-bank word.
REQ-012 Port dccm_wr_req, output, 1: write-port request.
REQ-013 Port dccm_wr_gnt, input, 1: write-port grant.
REQ-014 Port dccm_wr_addr, output, DCCM_BITS: word-aligned write address; bits [1:0] are 0.
REQ-015 Port dccm_wr_data, output, 39: write data, arranged as {ecc[6:0], data[31:0]}.
REQ-016 Port scrub_busy, output, 1: 1 when the queue is non-empty or a request is outstanding.
REQ-017 Port scrub_overflow, output, 1: one-cycle pulse whenever an entry is dropped.

Function
REQ-018 Lo push: in a cycle where single_ecc_error_lo_dc3=1 and the disable is 0, the block SHALL enqueue {lsu_addr_dc3[DCCM_BITS-1:2],2'b00} with sec_data_lo_dc3.
REQ-019 Hi push: in a cycle where single_ecc_error_hi_dc3=1 and the disable is 0, the block SHALL enqueue {end_addr_dc3[DCCM_BITS-1:2],2'b00} with sec_data_hi_dc3.
REQ-020 When both push in one cycle, the lo entry SHALL be ordered before the hi entry.
REQ-021 ECC SHALL be computed at enqueue using the core's standard (39,32) SECDED code (rvecc_encode equivalent), and stored in the queue with the data.
REQ-022 Free slots in a cycle SHALL equal DEPTH minus the current count, plus 1 if a pop occurs in that same cycle.
REQ-023 Pushes that exceed the free slots SHALL be dropped, with the hi entry dropped first.
REQ-024 scrub_overflow SHALL be 1 in the cycle after any drop.
REQ-025 FSM states SHALL be IDLE and REQ.
REQ-026 IDLE -> REQ SHALL occur on the clock edge where the queue is non-empty.
REQ-027 In REQ, dccm_wr_req=1 and dccm_wr_addr/dccm_wr_data SHALL equal the queue head and stay stable until granted.
REQ-028 A transfer SHALL occur when dccm_wr_req and dccm_wr_gnt are both 1; the head then pops at that edge.
REQ-029 After a transfer, the FSM SHALL stay in REQ if entries remain (back-to-back, one write per cycle), else go to IDLE.
REQ-030 dccm_wr_gnt while in IDLE SHALL be ignored.
REQ-031 Minimum latency SHALL be: push at edge N, dccm_wr_req=1 in cycle N+1.
REQ-032 Queue pointers SHALL wrap modulo DEPTH; the count SHALL range 0..DEPTH and never exceed DEPTH.
REQ-033 Asserting the disable SHALL NOT abort the FSM; queued entries still drain.
REQ-034 dccm_wr_addr and dccm_wr_data SHALL be 0 in IDLE.

Reset
REQ-035 While rst=1 at a clock edge, the block SHALL empty the queue, set the FSM to IDLE, and zero all outputs: dccm_wr_req, dccm_wr_addr, dccm_wr_data, scrub_busy, scrub_overflow.
REQ-036 Reset during REQ SHALL discard the outstanding request; a gnt in the reset cycle SHALL NOT be counted.
REQ-037 Pushes presented in a reset cycle SHALL be ignored.

Verification
REQ-038 Lo error, lsu_addr_dc3=16'h0106, sec_data_lo=0, gnt=1 -> next cycle req=1, addr=16'h0104, data=39'h0; following cycle req=0.
REQ-039 Dual error, lsu_addr=16'h0006, end_addr=16'h0009, gnt held 0 for 3 cycles -> req held with addr 16'h0004; on gnt, addr 16'h0008 in the next cycle.
REQ-040 Queue full (4 entries, gnt=0) plus a dual push -> both dropped, overflow pulses 1 cycle; full plus a dual push with gnt=1 -> lo accepted, hi dropped.
REQ-041 Single-bit data pattern 32'h1 -> dccm_wr_data[38:32] matches the golden encoder; flipping any bit must be correctable by the golden decoder.
REQ-042 rst asserted in REQ with gnt=1 -> next cycle req=0, busy=0, and that entry is never written.
REQ-043 Disable=1 with an error pulse -> no request; disable set while 2 entries are queued -> both still written.
